// File: rtl/rx_sample_packer.sv
// RX I/Q sample packer: buffers decimated {I,Q} pairs in a small FIFO and serialises
// them to the host as 16-bit words, I then Q. Optional macro: RX_OVR_COUNT_EN (dropped-pair counter).
//
// state  | meaning
// HALF_I | rd_data presents the I half of the head entry
// HALF_Q | rd_data presents the Q half; acking it retires the entry
module rx_sample_packer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  strobe_in,
    input  logic [15:0]           i_in,
    input  logic [15:0]           q_in,
    input  logic                  rd_ack,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  rd_is_q,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overrun,
    input  logic                  clear_overrun
`ifdef RX_OVR_COUNT_EN
    ,
    output logic [15:0]           ovr_count
`endif
);

    localparam int AW    = DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);

    typedef enum logic {
        HALF_I = 1'b0,
        HALF_Q = 1'b1
    } phase_t;

    phase_t        state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   head;
    logic [PW-1:0] stored_after_pop;
    logic [PW-1:0] visible;
    logic          wr_en;
    logic          ovr_evt;
    logic          pop_ok;
    logic          valid_nxt;
    logic [15:0]   data_nxt;
    logic [PW-1:0] level_nxt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= HALF_I;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid   <= 1'b0;
            rd_is_q    <= 1'b0;
            rd_data    <= '0;
            fifo_level <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            rd_valid   <= valid_nxt;
            rd_is_q    <= (state_nxt == HALF_Q);
            rd_data    <= data_nxt;
            fifo_level <= level_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {i_in, q_in};
        end
    end

    // Output regs are loaded from the next read state but the pre-write memory and
    // write pointer, which gives the one-cycle write-to-visible latency without a bypass.
    always_comb begin
        state_nxt        = state;
        rd_ptr_nxt       = rd_ptr;
        wr_ptr_nxt       = wr_ptr;
        wr_en            = 1'b0;
        ovr_evt          = 1'b0;
        pop_ok           = rd_ack && rd_valid;
        stored_after_pop = '0;

        if (!enable) begin
            rd_ptr_nxt = wr_ptr;
            state_nxt  = HALF_I;
        end else begin
            case (state)
                HALF_I: begin
                    if (pop_ok) begin
                        state_nxt = HALF_Q;
                    end
                end
                HALF_Q: begin
                    if (pop_ok) begin
                        state_nxt  = HALF_I;
                        rd_ptr_nxt = rd_ptr + 1'b1;
                    end
                end
                default: state_nxt = HALF_I;
            endcase

            // Fullness is judged after this cycle's pop so a Q-half ack frees the slot.
            stored_after_pop = wr_ptr - rd_ptr_nxt;
            if (strobe_in) begin
                if (stored_after_pop == FULL_LEVEL) begin
                    ovr_evt = 1'b1;
                end else begin
                    wr_en      = reset_n;
                    wr_ptr_nxt = wr_ptr + 1'b1;
                end
            end
        end

        head      = mem[rd_ptr_nxt[AW-1:0]];
        visible   = wr_ptr - rd_ptr_nxt;
        valid_nxt = enable && (visible != '0);
        data_nxt  = '0;
        if (valid_nxt) begin
            data_nxt = (state_nxt == HALF_Q) ? head[15:0] : head[31:16];
        end
        level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    // A new overrun event wins over a coincident clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (ovr_evt) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

`ifdef RX_OVR_COUNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ovr_count <= '0;
        end else if (clear_overrun) begin
            ovr_count <= ovr_evt ? 16'd1 : 16'd0;
        end else if (ovr_evt && (ovr_count != 16'hFFFF)) begin
            ovr_count <= ovr_count + 16'd1;
        end
    end
`endif

endmodule
